// File: rtl/pattern_detect_scheduler.sv
// Shares one pattern_detector between two byte requesters: round-robin grant, LSB-first
// serialization with flush/drain padding, and tag-aligned gathering of detector hits.
module pattern_detect_scheduler #(
  parameter int DET_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic        serial_pattern,
  output logic        enable,
  input  logic        pattern_detected,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_mask,
  output logic [3:0]  rsp_count,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DET_LAT - 1);
  localparam int         IW         = 3 * DET_LAT;

  state_t                   state_r, state_nxt_s;
  logic [2:0]               cnt_r, cnt_nxt_s;
  logic                     ptr_r, id_r, gnt_s, accept_s;
  logic [7:0]               shreg_r, mask_r;
  logic [3:0]               count_r;
  logic                     enable_r, sp_r, rsp_valid_r, err_r;
  logic                     enable_nxt_s, sp_nxt_s;
  logic [DET_LAT-1:0]       tag_v_r, en_d_r;
  logic [DET_LAT-1:0][2:0]  tag_idx_r;

  // State and phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and phase counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_nxt_s = FLUSH;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_r == 3'd1) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      SHIFT: begin
        if (cnt_r == 3'd7) begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = RESP;
          cnt_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Grant decode, accept pulse and next values of the registered detector drive
  always_comb begin
    gnt_s    = (&req_valid) ? ptr_r : req_valid[1];
    accept_s = (state_r == IDLE) && (|req_valid);
    if (accept_s) begin
      req_ready = gnt_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    enable_nxt_s = (state_nxt_s == FLUSH) || (state_nxt_s == SHIFT) || (state_nxt_s == DRAIN);
    if (state_nxt_s == SHIFT) begin
      sp_nxt_s = shreg_r[0];
    end else begin
      sp_nxt_s = 1'b0;
    end
  end

  // Datapath: capture, serialization, tag pipeline, hit accumulation and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      shreg_r     <= 8'h00;
      mask_r      <= 8'h00;
      count_r     <= 4'd0;
      enable_r    <= 1'b0;
      sp_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      tag_v_r     <= '0;
      en_d_r      <= '0;
      tag_idx_r   <= '0;
    end else begin
      enable_r    <= enable_nxt_s;
      sp_r        <= sp_nxt_s;
      rsp_valid_r <= (state_nxt_s == RESP);
      // Registered drive matches the state, so the current state/counter tags the bit on the wire
      tag_v_r     <= DET_LAT'({tag_v_r, (state_r == SHIFT)});
      tag_idx_r   <= IW'({tag_idx_r, cnt_r});
      en_d_r      <= DET_LAT'({en_d_r, enable_r});
      err_r       <= err_r | (pattern_detected & ~en_d_r[DET_LAT-1]);
      if (accept_s) begin
        ptr_r   <= ~gnt_s;
        id_r    <= gnt_s;
        shreg_r <= gnt_s ? req_data[15:8] : req_data[7:0];
        mask_r  <= 8'h00;
        count_r <= 4'd0;
      end else begin
        if (state_nxt_s == SHIFT) begin
          shreg_r <= {1'b0, shreg_r[7:1]};
        end
        if (tag_v_r[DET_LAT-1] && pattern_detected) begin
          mask_r[tag_idx_r[DET_LAT-1]] <= 1'b1;
          count_r                      <= count_r + 4'd1;
        end
      end
    end
  end

  assign enable         = enable_r;
  assign serial_pattern = sp_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_id         = id_r;
  assign rsp_mask       = mask_r;
  assign rsp_count      = count_r;
  assign err            = err_r;

endmodule

// File: doc/pattern_detect_scheduler.md
# pattern_detect_scheduler

Controller that shares one `pattern_detector` instance between two byte-wide requesters. It arbitrates round-robin between them, serializes the granted byte LSB-first onto the detector's `serial_pattern`/`enable` inputs, and gathers the detector's `pattern_detected` output into a per-bit hit mask and a hit count. It returns the mask and count to the granted requester over a valid/ready response channel. It sits directly upstream of the detector and is its only driver.

## Interface
Parameters:
- `DET_LAT`, default 1: cycles from `serial_pattern` being sampled (with `enable` high) to the matching `pattern_detected`; legal values 1..4.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `req_valid`  in  2  Per-requester byte request.
- `req_data`  in  16  Requester n's byte is `[8n+7:8n]`; held stable while `req_valid[n]` is high.
- `req_ready`  out  2  One-hot, one-cycle accept pulse.
- `serial_pattern`  out  1  To the detector; current bit.
- `enable`  out  1  To the detector.
- `pattern_detected`  in  1  From the detector.
- `rsp_valid`  out  1  Result available.
- `rsp_ready`  in  1  Consumer accepts the result.
- `rsp_id`  out  1  Requester the result belongs to.
- `rsp_mask`  out  8  Bit i set when the 3-bit window ending at data bit i holds exactly two ones.
- `rsp_count`  out  4  Popcount of `rsp_mask` (range 0..7).
- `err`  out  1  Sticky error: `pattern_detected` was high while `enable` was low.

## Operation
States: IDLE, FLUSH, SHIFT, DRAIN, RESP.

- **IDLE**
  - `enable` = 0.
  - If any `req_valid` is set, grant one requester:
    - a single valid requester wins;
    - if both are valid, the requester named by the priority pointer `ptr` wins.
  - On grant: pulse `req_ready[g]`, capture `req_data` byte g into `shreg` and g into `id`, clear mask and count, set `ptr` = ~g, go to FLUSH.
- **FLUSH** (2 cycles)
  - `enable` = 1, `serial_pattern` = 0, bits tagged invalid.
  - Purges detector history, so bits before bit 0 read as 0.
  - Then go to SHIFT.
- **SHIFT** (8 cycles)
  - `enable` = 1, `serial_pattern` = `shreg[0]`; `shreg` shifts right once per cycle.
  - Bit i is driven on SHIFT cycle i and tagged valid with index i.
- **DRAIN** (`DET_LAT` cycles)
  - `enable` = 1, `serial_pattern` = 0, bits tagged invalid.
  - Then go to RESP.
- **Tag pipeline**
  - A `DET_LAT`-deep pipeline carries {valid, index} alongside each driven bit.
  - When the delayed tag is valid and `pattern_detected` = 1, set `mask[index]` and increment `count`.
- **RESP**
  - `enable` = 0; `rsp_valid` = 1 with `id`, mask and count held stable.
  - When `rsp_valid` and `rsp_ready` are both high, go to IDLE.
- **err**
  - Set on any cycle where `pattern_detected` is high while `enable` was low `DET_LAT` cycles earlier.
  - Cleared only by `rst`.
- **Arithmetic**: count saturates at 7 by construction (bit 0's window can never hold two ones); no wrap.

## Timing
- **Reset values**: state IDLE, `ptr` = 0, and every output 0 (`req_ready`, `serial_pattern`, `enable`, `rsp_valid`, `rsp_id`, `rsp_mask`, `rsp_count`, `err`). The tag pipeline is also cleared.
- **Reset mid-operation**: `rst` has priority in any state. The next cycle is IDLE with `enable` low; the in-flight byte is dropped and no response is produced.
- **Accept**: `req_ready` is high for exactly the IDLE cycle in which the grant is made. It is never asserted outside IDLE.
- **Latency**: the first SHIFT cycle is 3 cycles after the accept edge. `rsp_valid` rises 2+8+`DET_LAT` cycles after the cycle following accept (11 cycles for `DET_LAT` = 1).
- **Back-to-back**: the cycle after the response handshake is IDLE, so the earliest next `req_ready` is one cycle after that handshake.
- **Response**: `rsp_valid` stays high until the handshake. With `rsp_ready` tied high, `rsp_valid` is a single-cycle pulse.
- **Simultaneous requests**: both valid in IDLE -> the `ptr` winner is granted and the other requester is granted next. The losing requester keeps `req_valid` high.
- `req_valid` deasserting while not granted is legal; nothing is captured.

## Test plan
- **Reset**: hold `rst` 2 cycles mid-SHIFT. Required: all outputs 0 next cycle, no `rsp_valid`, and the next request is granted normally.
- **Byte 0x55** from requester 0, `rsp_ready` = 1. Required: `rsp_mask` = 0x54, `rsp_count` = 3, `rsp_id` = 0, `rsp_valid` 11 cycles after the cycle following `req_ready`.
- **Bytes 0xFF and 0x36**, both corner values:
  - 0xFF -> `rsp_mask` = 0x02, count 1;
  - 0x36 -> `rsp_mask` = 0x7C, count 5.
- **Byte 0x00** -> `rsp_mask` = 0x00, count 0.
- **Arbitration**: both requesters valid continuously. Grants alternate 0,1,0,1 and each `rsp_id` matches its grant. Holding `rsp_ready` low 5 cycles stretches RESP and issues no `req_ready`.
- **Random 200 bytes** per `DET_LAT` in {1,3}:
  - `rsp_mask` matches the reference model "window of bits i-2..i (out-of-range = 0) has exactly two ones";
  - `enable` is low in IDLE/RESP;
  - `err` stays 0. Forcing `pattern_detected` high in IDLE sets `err`.
